dir_controller_n: RTL and testbench
===================================

Name: dir_controller_n

Overview:
- Parametrised successor to the single-line, single-requester directory FSM.
- Holds a full-map directory for NLINES cache lines shared by NPROC processors. Each line has a state (Uncached/Shared/Exclusive) and an NPROC-bit sharer vector.
- Serialises requests through a valid/ready handshake. Issues per-processor invalidates and owner fetches, and waits for the owner's fetch acknowledge before replying.

Parameters:
- PID_W, 2, processor-id width; NPROC = 2**PID_W.
- LINE_W, 3, line-index width; NLINES = 2**LINE_W.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_op  in  2  00 read miss, 01 read hit (no-op), 10 data writeback, 11 write miss
- req_pid  in  PID_W  requesting processor
- req_line  in  LINE_W  directory line index
- rsp_valid  out  1  one-cycle completion pulse
- data_value_reply  out  1  high with rsp_valid when data is returned to the requester
- err  out  1  one-cycle pulse with rsp_valid for an illegal request
- inval_valid  out  1  one-cycle invalidate pulse
- inval_mask  out  NPROC  processors to invalidate
- fetch_valid  out  1  fetch request to the owner, held until acknowledged
- fetch_inval  out  1  with fetch_valid: 0 fetch, 1 fetch-invalidate
- fetch_pid  out  PID_W  owner being fetched
- fetch_ack  in  1  owner has written back; sampled while fetch_valid=1

Behaviour:
- Reset: all lines go Uncached with sharers=0; FSM goes to IDLE. All outputs are 0 except req_ready=1 in the cycle after reset. Reset mid-operation aborts any fetch wait and no reply is issued.
- FSM states: IDLE, LOOKUP, FETCH, REPLY.
  - IDLE: req_ready=1. On req_valid, capture op/pid/line and go to LOOKUP.
  - LOOKUP: read the entry and decide. Go to FETCH if a fetch is needed, otherwise go to REPLY.
  - FETCH: hold fetch_valid/fetch_inval/fetch_pid stable. When fetch_ack=1, go to REPLY. fetch_ack outside FETCH is ignored.
  - REPLY: write the entry and pulse rsp_valid, plus data_value_reply/inval_valid/err as required, then return to IDLE.
- Latency: accept at edge N, rsp_valid during cycle N+2 when no fetch is needed. With a fetch, rsp_valid comes one cycle after the ack edge. Throughput without fetch is one request per 3 cycles.
- Transitions (p = req_pid, o = owner = the single set bit of sharers in Exclusive):
  - Uncached + read miss: go Shared, sharers={p}, reply=1.
  - Uncached + write miss: go Exclusive, sharers={p}, reply=1.
  - Shared + read miss: stay Shared, sharers |= {p}, reply=1. Idempotent if p is already a sharer.
  - Shared + write miss: inval_mask = sharers & ~{p}. inval_valid=1 only if the mask is nonzero. Go Exclusive, sharers={p}, reply=1.
  - Exclusive + read miss, p!=o: fetch (fetch_inval=0) to o. After ack, go Shared, sharers={o,p}, reply=1.
  - Exclusive + write miss, p!=o: fetch-invalidate (fetch_inval=1) to o. After ack, stay Exclusive, sharers={p}, reply=1.
  - Exclusive + read or write miss, p==o: no state change, reply=1.
  - Exclusive + writeback, p==o: go Uncached, sharers=0, rsp_valid=1, reply=0.
  - Read hit (01), any state: no change, rsp_valid=1, reply=0.
  - Writeback in Uncached/Shared, or from a non-owner: err=1, rsp_valid=1, reply=0, no change.
- Only the addressed line is modified. Other lines are untouched.
- inval_mask is 0 whenever inval_valid=0. fetch_pid/fetch_inval are 0 when fetch_valid=0.

Test Plan:
- Reset, then P0 read miss on line 2 -> rsp_valid 2 cycles after accept, reply=1. Line 2 becomes Shared, sharers=0001.
- P1 and P3 read miss line 2, then P2 write miss line 2 -> inval_valid=1, inval_mask=1011. Line 2 becomes Exclusive, sharers=0100.
- P1 write miss on Exclusive line 2 owned by P2 -> fetch_valid=1, fetch_inval=1, fetch_pid=2, held for 5 cycles. Drive fetch_ack, then rsp_valid on the next cycle. Owner becomes P1.
- P0 read miss on a line owned by P3 -> fetch_inval=0 to P3. After ack, line is Shared with sharers=1001.
- P3 writeback on its Exclusive line -> reply=0, line becomes Uncached, sharers=0. A repeated writeback -> err=1.
- Assert reset during FETCH -> fetch_valid=0 next cycle and all lines Uncached. A later fetch_ack has no effect and no rsp_valid is issued.

Source files
------------

// File: rtl/dir_controller_n.sv
// Full-map directory controller for NLINES lines shared by NPROC processors.
// Requests are serialised IDLE->LOOKUP->(FETCH)->REPLY; the entry is written only in REPLY.
module dir_controller_n #(
  parameter int PID_W  = 2,
  parameter int LINE_W = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [PID_W-1:0]      req_pid,
  input  logic [LINE_W-1:0]     req_line,
  output logic                  rsp_valid,
  output logic                  data_value_reply,
  output logic                  err,
  output logic                  inval_valid,
  output logic [2**PID_W-1:0]   inval_mask,
  output logic                  fetch_valid,
  output logic                  fetch_inval,
  output logic [PID_W-1:0]      fetch_pid,
  input  logic                  fetch_ack
);
  localparam int NPROC  = 2**PID_W;
  localparam int NLINES = 2**LINE_W;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FETCH, S_REPLY} fsm_t;
  typedef enum logic [1:0] {L_UNC, L_SHR, L_EXC} lst_t;
  localparam logic [1:0] OP_RD_MISS = 2'b00;
  localparam logic [1:0] OP_RD_HIT  = 2'b01;
  localparam logic [1:0] OP_WB      = 2'b10;

  fsm_t state, state_nxt;

  lst_t             dir_st [NLINES];
  logic [NPROC-1:0] dir_sh [NLINES];

  logic [1:0]        op_q;
  logic [PID_W-1:0]  pid_q;
  logic [LINE_W-1:0] line_q;

  // Decision captured in LOOKUP and applied in REPLY
  lst_t             nst_q;
  logic [NPROC-1:0] nsh_q, inv_q;
  logic             reply_q, err_q, finv_q;
  logic [PID_W-1:0] owner_q;

  lst_t             cur_st, d_st;
  logic [NPROC-1:0] cur_sh, d_sh, d_inv, pbit;
  logic [PID_W-1:0] owner;
  logic             d_reply, d_err, d_fetch, d_finv;

  always_comb begin
    cur_st = dir_st[line_q];
    cur_sh = dir_sh[line_q];
    pbit   = '0;
    pbit[pid_q] = 1'b1;
    owner  = '0;
    for (int i = 0; i < NPROC; i++)
      if (cur_sh[i]) owner = PID_W'(i);
  end

  always_comb begin
    d_st = cur_st; d_sh = cur_sh; d_inv = '0;
    d_reply = 1'b0; d_err = 1'b0; d_fetch = 1'b0; d_finv = 1'b0;
    case (op_q)
      OP_RD_HIT: ;
      OP_WB: begin
        if (cur_st == L_EXC && owner == pid_q) begin
          d_st = L_UNC; d_sh = '0;
        end else d_err = 1'b1;
      end
      OP_RD_MISS: begin
        d_reply = 1'b1;
        if (cur_st == L_EXC) begin
          if (owner != pid_q) begin
            d_fetch = 1'b1; d_st = L_SHR; d_sh = cur_sh | pbit;
          end
        end else begin
          d_st = L_SHR; d_sh = cur_sh | pbit;
        end
      end
      default: begin
        d_reply = 1'b1;
        d_st = L_EXC; d_sh = pbit;
        if (cur_st == L_SHR) d_inv = cur_sh & ~pbit;
        if (cur_st == L_EXC && owner != pid_q) begin
          d_fetch = 1'b1; d_finv = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = d_fetch ? S_FETCH : S_REPLY;
      S_FETCH:  if (fetch_ack) state_nxt = S_REPLY;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready        = (state == S_IDLE);
    rsp_valid        = (state == S_REPLY);
    data_value_reply = (state == S_REPLY) && reply_q;
    err              = (state == S_REPLY) && err_q;
    inval_valid      = (state == S_REPLY) && (|inv_q);
    inval_mask       = (state == S_REPLY) ? inv_q : '0;
    fetch_valid      = (state == S_FETCH);
    fetch_inval      = (state == S_FETCH) && finv_q;
    fetch_pid        = (state == S_FETCH) ? owner_q : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NLINES; i++) begin
        dir_st[i] <= L_UNC;
        dir_sh[i] <= '0;
      end
      op_q <= '0; pid_q <= '0; line_q <= '0;
      nst_q <= L_UNC; nsh_q <= '0; inv_q <= '0;
      reply_q <= 1'b0; err_q <= 1'b0; finv_q <= 1'b0; owner_q <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        op_q <= req_op; pid_q <= req_pid; line_q <= req_line;
      end
      if (state == S_LOOKUP) begin
        nst_q <= d_st; nsh_q <= d_sh; inv_q <= d_inv;
        reply_q <= d_reply; err_q <= d_err; finv_q <= d_finv; owner_q <= owner;
      end
      if (state == S_REPLY) begin
        dir_st[line_q] <= nst_q;
        dir_sh[line_q] <= nsh_q;
      end
    end
  end
endmodule

// File: tb/tb_dir_controller_n.sv
// Randomised bench for dir_controller_n against a transaction-level directory model.
module tb_dir_controller_n;
  localparam int PID_W = 2, LINE_W = 3, NPROC = 4, NLINES = 8;
  localparam int UN = 0, SH = 1, EX = 2;

  logic clock = 1'b0, reset = 1'b1, req_valid = 1'b0, fetch_ack = 1'b0;
  logic [1:0] req_op = '0;
  logic [PID_W-1:0] req_pid = '0;
  logic [LINE_W-1:0] req_line = '0;
  logic req_ready, rsp_valid, data_value_reply, err, inval_valid, fetch_valid, fetch_inval;
  logic [NPROC-1:0] inval_mask;
  logic [PID_W-1:0] fetch_pid;

  dir_controller_n #(.PID_W(PID_W), .LINE_W(LINE_W)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_pid(req_pid), .req_line(req_line), .rsp_valid(rsp_valid),
    .data_value_reply(data_value_reply), .err(err), .inval_valid(inval_valid),
    .inval_mask(inval_mask), .fetch_valid(fetch_valid), .fetch_inval(fetch_inval),
    .fetch_pid(fetch_pid), .fetch_ack(fetch_ack));

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  int m_st [NLINES];
  logic [NPROC-1:0] m_sh [NLINES];
  // Last observed reply/fetch values, used by the directed literal checks
  logic o_reply, o_err, o_iv, o_finv;
  logic [NPROC-1:0] o_mask;
  logic [PID_W-1:0] o_fpid;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int rdy, input int rv, input int rep,
                         input int er, input int iv, input int im, input int fv,
                         input int fi, input int fp);
    chk({tag, ".req_ready"}, req_ready, rdy);
    chk({tag, ".rsp_valid"}, rsp_valid, rv);
    chk({tag, ".reply"}, data_value_reply, rep);
    chk({tag, ".err"}, err, er);
    chk({tag, ".inval_valid"}, inval_valid, iv);
    chk({tag, ".inval_mask"}, inval_mask, im);
    chk({tag, ".fetch_valid"}, fetch_valid, fv);
    chk({tag, ".fetch_inval"}, fetch_inval, fi);
    chk({tag, ".fetch_pid"}, fetch_pid, fp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NLINES; i++) begin
      m_st[i] = UN; m_sh[i] = '0;
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge that ends REPLY.
  task automatic do_req(input logic [1:0] op, input int pid, input int line, input int ack_dly);
    logic [NPROC-1:0] pb, sh, e_inv, n_sh;
    int st, own, n_st;
    bit e_fetch, e_finv, e_reply, e_err;
    pb = NPROC'(1 << pid);
    sh = m_sh[line]; st = m_st[line]; own = 0;
    for (int i = 0; i < NPROC; i++) if (sh[i]) own = i;
    e_fetch = 0; e_finv = 0; e_reply = 0; e_err = 0; e_inv = '0; n_st = st; n_sh = sh;
    case (op)
      2'b01: ;
      2'b10: if (st == EX && sh == pb) begin n_st = UN; n_sh = '0; end else e_err = 1;
      default: begin
        e_reply = 1;
        if (st == EX && sh != pb) begin e_fetch = 1; e_finv = (op == 2'b11); end
        if (op == 2'b00) begin
          if (!(st == EX && sh == pb)) begin n_st = SH; n_sh = sh | pb; end
        end else begin
          if (st == SH) e_inv = sh & ~pb;
          n_st = EX; n_sh = pb;
        end
      end
    endcase

    chk_out("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    req_op = op; req_pid = PID_W'(pid); req_line = LINE_W'(line); req_valid = 1'b1;
    @(posedge clock); #1 req_valid = 1'b0;
    chk_out("lookup", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    if (e_fetch) begin
      for (int k = 0; k < ack_dly; k++) begin
        chk_out("fetch", 0, 0, 0, 0, 0, 0, 1, int'(e_finv), own);
        o_fpid = fetch_pid; o_finv = fetch_inval;
        if (k == ack_dly - 1) fetch_ack = 1'b1;
        @(posedge clock); #1;
      end
      fetch_ack = 1'b0;
    end
    chk_out("reply", 0, 1, int'(e_reply), int'(e_err), int'(e_inv != 0), e_inv, 0, 0, 0);
    o_reply = data_value_reply; o_err = err; o_iv = inval_valid; o_mask = inval_mask;
    m_st[line] = n_st; m_sh[line] = n_sh;
    @(posedge clock); #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk_out("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed scenario with hand-computed expectations
    do_req(2'b00, 0, 2, 1);
    chk("p0_rd.reply", o_reply, 1);
    chk("p0_rd.model_sh", m_sh[2], 4'b0001);
    do_req(2'b00, 1, 2, 1);
    do_req(2'b00, 3, 2, 1);
    do_req(2'b11, 2, 2, 1);
    chk("p2_wr.inval_valid", o_iv, 1);
    chk("p2_wr.inval_mask", o_mask, 4'b1011);
    chk("p2_wr.model_sh", m_sh[2], 4'b0100);
    do_req(2'b11, 1, 2, 5);
    chk("p1_wr.fetch_pid", o_fpid, 2);
    chk("p1_wr.fetch_inval", o_finv, 1);
    chk("p1_wr.model_sh", m_sh[2], 4'b0010);
    do_req(2'b11, 3, 5, 1);
    do_req(2'b00, 0, 5, 2);
    chk("p0_rd5.fetch_pid", o_fpid, 3);
    chk("p0_rd5.fetch_inval", o_finv, 0);
    chk("p0_rd5.model_sh", m_sh[5], 4'b1001);
    do_req(2'b11, 3, 6, 1);
    do_req(2'b10, 3, 6, 1);
    chk("wb.reply", o_reply, 0);
    chk("wb.err", o_err, 0);
    do_req(2'b10, 3, 6, 1);
    chk("wb2.err", o_err, 1);
    do_req(2'b01, 2, 6, 1);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int k = 0; k < g; k++) begin
        @(posedge clock); #1;
        chk_out("gap", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      do_req(2'($urandom_range(0, 3)), $urandom_range(0, NPROC-1),
             $urandom_range(0, NLINES-1), $urandom_range(1, 4));
    end

    // Reset while waiting on a fetch
    do_req(2'b11, 1, 1, 1);
    req_op = 2'b00; req_pid = '0; req_line = 3'd1; req_valid = 1'b1;
    @(posedge clock); #1 req_valid = 1'b0;
    @(posedge clock); #1;
    for (int k = 0; k < 2; k++) begin
      chk_out("pre_rst_fetch", 0, 0, 0, 0, 0, 0, 1, 0, 1);
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    model_reset();
    chk_out("rst_abort", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    fetch_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      chk_out("late_ack", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    fetch_ack = 1'b0;
    for (int l = 0; l < NLINES; l++) begin
      do_req(2'b10, 0, l, 1);
      chk("rst_unc.err", o_err, 1);
    end
    do_req(2'b00, 2, 1, 1);
    chk("rst_unc.rd_reply", o_reply, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
